frame_write_scheduler: RTL and testbench

//  Sequences all draw sources (background, sprites, overlays) onto the shared frame-buffer write bus once per frame.

---
 rtl/frame_write_scheduler.sv | 156 +++++++++++++++
 tb/tb_frame_write_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_scheduler.sv
// Hands the shared frame-buffer write bus to each enabled draw source in ascending ID order, once per frame.
// Optional per-wait watchdog is enabled by defining WRITE_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | bus released, waiting for frame_start or a pending start
// CHECK        | test enable of source idx, skip disabled sources
// GRANT        | sel stable, one-cycle write_awaited pulse
// AWAIT_START  | wait for the granted source to raise write_active
// AWAIT_END    | wait for the burst to finish, then release the bus
// FRAME_DONE   | one-cycle frame_done, return to IDLE
module frame_write_scheduler #(
    parameter int NUM_SOURCES      = 4,
    parameter int SOURCE_SEL_ADDRW = 3,
    parameter int TIMEOUT_CYCLES   = 400000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [NUM_SOURCES-1:0]      source_enable,
    input  logic                        write_active,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    output logic                        frame_busy,
    output logic                        frame_done,
    output logic [7:0]                  overrun_count,
    output logic [NUM_SOURCES-1:0]      timeout_err
);

    localparam logic [SOURCE_SEL_ADDRW-1:0] IDLE_SEL = '1;
    localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_IDX = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
    localparam logic [NUM_SOURCES-1:0]      SRC0_BIT = NUM_SOURCES'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_GRANT, S_AWAIT_START, S_AWAIT_END, S_FRAME_DONE
    } state_t;

    state_t                        state, state_nxt;
    logic [SOURCE_SEL_ADDRW-1:0]   idx, idx_nxt;
    logic [SOURCE_SEL_ADDRW-1:0]   sel_q, sel_nxt;
    logic [NUM_SOURCES-1:0]        enabled;
    logic                          pending;
    logic                          accept;
    logic                          release_src;
    logic                          wait_hit;
    logic                          active;
    logic                          en_cur;

    // Only a clean 1 counts as an active strobe; Z/X from a floating bus reads as idle.
    assign active  = (write_active === 1'b1);
    assign en_cur  = |(enabled & (SRC0_BIT << idx));

    assign write_source_sel = sel_q;
    assign write_awaited    = (state == S_GRANT);
    assign frame_busy       = (state != S_IDLE);
    assign frame_done       = (state == S_FRAME_DONE);

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        sel_nxt     = sel_q;
        accept      = 1'b0;
        release_src = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start || pending) begin
                    accept    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (en_cur) begin
                    sel_nxt   = idx;
                    state_nxt = S_GRANT;
                end else if (idx == LAST_IDX) begin
                    state_nxt = S_FRAME_DONE;
                end else begin
                    idx_nxt = idx + SOURCE_SEL_ADDRW'(1);
                end
            end
            S_GRANT: state_nxt = S_AWAIT_START;
            S_AWAIT_START: begin
                if (active)        state_nxt   = S_AWAIT_END;
                else if (wait_hit) release_src = 1'b1;
            end
            S_AWAIT_END: begin
                if (!active || wait_hit) release_src = 1'b1;
            end
            S_FRAME_DONE: begin
                sel_nxt   = IDLE_SEL;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (release_src) begin
            sel_nxt = IDLE_SEL;
            if (idx == LAST_IDX) begin
                state_nxt = S_FRAME_DONE;
            end else begin
                idx_nxt   = idx + SOURCE_SEL_ADDRW'(1);
                state_nxt = S_CHECK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            idx           <= '0;
            sel_q         <= IDLE_SEL;
            enabled       <= '0;
            pending       <= 1'b0;
            overrun_count <= 8'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            sel_q <= sel_nxt;
            if (accept) begin
                enabled <= source_enable;
                pending <= 1'b0;
            end else if (frame_start && state != S_IDLE) begin
                pending <= 1'b1;
                if (pending && overrun_count != 8'hFF)
                    overrun_count <= overrun_count + 8'd1;
            end
        end
    end

`ifdef WRITE_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wait_cnt;
    logic        tmo_set;

    assign wait_hit = (state == S_AWAIT_START || state == S_AWAIT_END) && (wait_cnt >= TMO_LAST);
    assign tmo_set  = wait_hit && ((state == S_AWAIT_START && !active) ||
                                   (state == S_AWAIT_END && active));

    // Counter restarts whenever the FSM moves, so each wait phase gets a full budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= 32'd0;
            timeout_err <= '0;
        end else begin
            if (state_nxt != state) wait_cnt <= 32'd0;
            else                    wait_cnt <= wait_cnt + 32'd1;
            if (accept)       timeout_err <= '0;
            else if (tmo_set) timeout_err <= timeout_err | (SRC0_BIT << idx);
        end
    end
`else
    assign wait_hit    = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed bench for frame_write_scheduler with a behavioural draw-source model.
// Define WRITE_TIMEOUT_EN at compile time to also exercise the watchdog.
module tb_frame_write_scheduler;

`ifdef WRITE_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 400000;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [3:0] source_enable;
    logic       write_active;
    logic [2:0] write_source_sel;
    logic       write_awaited;
    logic       frame_busy;
    logic       frame_done;
    logic [7:0] overrun_count;
    logic [3:0] timeout_err;

    int checks   = 0;
    int failures = 0;

    int       burst_len = 10;
    logic [3:0] src_silent = 4'b0000;
    int       done_cnt  = 0;
    int       await_cnt = 0;
    int       grants[$];

    frame_write_scheduler #(
        .NUM_SOURCES(4), .SOURCE_SEL_ADDRW(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .source_enable(source_enable),
        .write_active(write_active), .write_source_sel(write_source_sel),
        .write_awaited(write_awaited), .frame_busy(frame_busy), .frame_done(frame_done),
        .overrun_count(overrun_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_cnt != start), 32'd1);
    endtask

    // Source model: answers each write_awaited with a burst after a short delay.
    initial begin
        write_active = 1'b0;
        forever begin
            @(negedge clk);
            if (write_awaited === 1'b1 && !src_silent[write_source_sel[1:0]]) begin
                repeat (2) @(negedge clk);
                write_active = 1'b1;
                repeat (burst_len) @(negedge clk);
                write_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (write_awaited) begin
                await_cnt++;
                grants.push_back(int'(write_source_sel));
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        int first_done;
        reset         = 1'b1;
        frame_start   = 1'b0;
        source_enable = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_sel",     32'(write_source_sel), 32'd7);
        check("rst_awaited", 32'(write_awaited),    32'd0);
        check("rst_busy",    32'(frame_busy),       32'd0);
        check("rst_done",    32'(frame_done),       32'd0);
        check("rst_overrun", 32'(overrun_count),    32'd0);
        check("rst_tmo",     32'(timeout_err),      32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: all sources enabled
        source_enable = 4'b1111;
        grants.delete(); await_cnt = 0; done_cnt = 0;
        pulse_start();
        check("t1_busy_start", 32'(frame_busy), 32'd1);
        wait_done("t1_done");
        repeat (3) @(negedge clk);
        check("t1_awaits", 32'(await_cnt), 32'd4);
        check("t1_ngrant", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("t1_grant%0d", i), 32'(grants[i]), 32'(i));
        check("t1_done_once", 32'(done_cnt), 32'd1);
        check("t1_busy_after", 32'(frame_busy), 32'd0);
        check("t1_sel_idle", 32'(write_source_sel), 32'd7);
`ifndef WRITE_TIMEOUT_EN
        check("t1_tmo_zero", 32'(timeout_err), 32'd0);
`endif

        // 2: sparse enable
        source_enable = 4'b0101;
        grants.delete(); await_cnt = 0; done_cnt = 0;
        pulse_start();
        source_enable = 4'b1010;
        wait_done("t2_done");
        repeat (3) @(negedge clk);
        check("t2_ngrant", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            check("t2_grant0", 32'(grants[0]), 32'd0);
            check("t2_grant1", 32'(grants[1]), 32'd2);
        end
        check("t2_done_once", 32'(done_cnt), 32'd1);

        // 3: nothing enabled, exact frame_done latency
        source_enable = 4'b0000;
        grants.delete(); await_cnt = 0;
        first_done = 0;
        @(negedge clk) frame_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (frame_done && first_done == 0) first_done = i;
        end
        check("t3_done_latency", 32'(first_done), 32'd5);
        check("t3_no_await", 32'(await_cnt), 32'd0);
        check("t3_busy_after", 32'(frame_busy), 32'd0);

`ifdef WRITE_TIMEOUT_EN
        // 5: source 1 silent, watchdog must skip it
        source_enable = 4'b1111;
        src_silent = 4'b0010;
        grants.delete(); done_cnt = 0;
        pulse_start();
        wait_done("t5_done");
        repeat (3) @(negedge clk);
        check("t5_tmo", 32'(timeout_err), 32'b0010);
        check("t5_ngrant", 32'(grants.size()), 32'd4);
        if (grants.size() == 4) check("t5_grant3", 32'(grants[3]), 32'd3);
        src_silent = 4'b0000;
`endif

        // 4: three starts while busy -> overrun 2, one extra frame
        source_enable = 4'b1111;
        grants.delete(); done_cnt = 0;
        pulse_start();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            repeat (3) @(negedge clk);
        end
        check("t4_overrun", 32'(overrun_count), 32'd2);
        wait_done("t4_done1");
        wait_done("t4_done2");
        repeat (60) @(negedge clk);
        check("t4_frames", 32'(done_cnt), 32'd2);
        check("t4_grants", 32'(grants.size()), 32'd8);
        check("t4_busy_after", 32'(frame_busy), 32'd0);

        // overrun saturation with a long burst
        burst_len = 800;
        source_enable = 4'b0001;
        done_cnt = 0;
        pulse_start();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 300; i++) pulse_start();
        check("sat_overrun", 32'(overrun_count), 32'd255);
        wait_done("sat_done1");
        wait_done("sat_done2");
        burst_len = 10;
        repeat (20) @(negedge clk);

        // 6: reset in the middle of source 2's burst
        source_enable = 4'b1111;
        grants.delete();
        pulse_start();
        begin
            int n = 0;
            while (!(write_active && write_source_sel == 3'd2) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("t6_reach_src2", 32'(write_source_sel), 32'd2);
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_sel_async",  32'(write_source_sel), 32'd7);
        check("t6_busy_async", 32'(frame_busy),       32'd0);
        check("t6_overrun",    32'(overrun_count),    32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_idle_after", 32'(frame_busy), 32'd0);
        check("t6_sel_after",  32'(write_source_sel), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
